// File: rtl/stage_memory.sv
// MEM stage: issues the data-memory access for loads and stores, stalls the
// pipeline on memory latency, and registers the MEM/WB bundle.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction outstanding; a new request may be issued
// REQ   | request presented, memory has not accepted it yet
// RESP  | load accepted, waiting for the read data
module stage_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_alu_out,
    input  logic [DATA_WIDTH-1:0] in_mem_in_data,
    input  logic [4:0]            in_rd,
    input  logic [2:0]            in_funct3,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic                  in_mem_to_reg,
    input  logic                  in_write_enable,
    output logic                  out_dmem_req_valid,
    input  logic                  in_dmem_req_ready,
    output logic [ADDR_WIDTH-1:0] out_dmem_addr,
    output logic                  out_dmem_we,
    output logic [3:0]            out_dmem_wstrb,
    output logic [DATA_WIDTH-1:0] out_dmem_wdata,
    input  logic                  in_dmem_resp_valid,
    input  logic [DATA_WIDTH-1:0] in_dmem_rdata,
    output logic                  out_stall,
    output logic                  out_valid,
    output logic [4:0]            out_rd,
    output logic                  out_write_enable,
    output logic                  out_mem_to_reg,
    output logic [DATA_WIDTH-1:0] out_alu_out,
    output logic [DATA_WIDTH-1:0] out_mem_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0] byte_off;
    logic       mem_op;
    logic       is_store;
    logic       misaligned;
    logic       aligned_op;
    logic       req_valid_c;
    logic       stall_c;
    logic       load_done;

    logic [3:0]            wstrb_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_ext;

    logic                  valid_q;
    logic [4:0]            rd_q;
    logic                  we_q;
    logic                  m2r_q;
    logic [DATA_WIDTH-1:0] alu_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic                  mis_q;

    // A simultaneous read+write is a store; funct3[1] marks word size.
    assign byte_off   = in_alu_out[1:0];
    assign mem_op     = in_valid & (in_mem_read | in_mem_write);
    assign is_store   = in_mem_write;
    assign misaligned = mem_op & ((in_funct3[1] & (byte_off != 2'b00)) |
                                  ((in_funct3[1:0] == 2'b01) & byte_off[0]));
    assign aligned_op = mem_op & ~misaligned;

    // Store lane placement: narrow data is replicated across the word.
    always_comb begin
        wstrb_c = 4'b1111;
        wdata_c = in_mem_in_data;
        case (in_funct3[1:0])
            2'b00: begin
                wstrb_c = 4'b0001 << byte_off;
                wdata_c = {4{in_mem_in_data[7:0]}};
            end
            2'b01: begin
                wstrb_c = 4'b0011 << {byte_off[1], 1'b0};
                wdata_c = {2{in_mem_in_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        ld_byte = in_dmem_rdata[{byte_off, 3'b000} +: 8];
        ld_half = byte_off[1] ? in_dmem_rdata[31:16] : in_dmem_rdata[15:0];
        case (in_funct3)
            3'b000:  ld_ext = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: ld_ext = in_dmem_rdata;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (aligned_op) begin
                    if (!in_dmem_req_ready) state_d = REQ;
                    else if (!is_store)     state_d = RESP;
                end
            end
            REQ: begin
                if (in_dmem_req_ready) state_d = is_store ? IDLE : RESP;
            end
            RESP: begin
                if (in_dmem_resp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: request valid and pipeline stall.
    always_comb begin
        req_valid_c = 1'b0;
        stall_c     = 1'b0;
        load_done   = 1'b0;
        case (state_q)
            IDLE: begin
                req_valid_c = aligned_op;
                stall_c     = aligned_op & ~(is_store & in_dmem_req_ready);
            end
            REQ: begin
                req_valid_c = 1'b1;
                stall_c     = ~(is_store & in_dmem_req_ready);
            end
            RESP: begin
                stall_c   = ~in_dmem_resp_valid;
                load_done = in_dmem_resp_valid;
            end
            default: ;
        endcase
    end

    // MEM/WB register: bubble while stalled, otherwise capture the instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            m2r_q      <= 1'b0;
            alu_q      <= '0;
            mem_data_q <= '0;
            mis_q      <= 1'b0;
        end else if (stall_c) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            rd_q    <= in_rd;
            we_q    <= in_write_enable & ~misaligned;
            m2r_q   <= in_mem_to_reg;
            alu_q   <= in_alu_out;
            mis_q   <= misaligned;
            if (load_done) mem_data_q <= ld_ext;
        end
    end

    // Request outputs are forced quiet while reset is held.
    assign out_dmem_req_valid = req_valid_c & reset;
    assign out_stall          = stall_c & reset;
    assign out_dmem_addr      = {in_alu_out[ADDR_WIDTH-1:2], 2'b00};
    assign out_dmem_we        = is_store;
    assign out_dmem_wstrb     = wstrb_c;
    assign out_dmem_wdata     = wdata_c;

    assign out_valid        = valid_q;
    assign out_rd           = rd_q;
    assign out_write_enable = we_q;
    assign out_mem_to_reg   = m2r_q;
    assign out_alu_out      = alu_q;
    assign out_mem_data     = mem_data_q;
    assign out_misaligned   = mis_q;
    assign out_data         = m2r_q ? mem_data_q : alu_q;

endmodule

// File: tb/tb_stage_memory.sv
// Testbench for stage_memory: directed vectors plus a randomized run
// against a transaction-level model of the memory stage.
module tb_stage_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid, in_mem_read, in_mem_write, in_mem_to_reg, in_write_enable;
    logic [31:0] in_alu_out, in_mem_in_data, in_dmem_rdata;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic        in_dmem_req_ready, in_dmem_resp_valid;
    logic        out_dmem_req_valid, out_dmem_we, out_stall, out_valid;
    logic        out_write_enable, out_mem_to_reg, out_misaligned;
    logic [31:0] out_dmem_addr, out_dmem_wdata, out_alu_out, out_mem_data, out_data;
    logic [3:0]  out_dmem_wstrb;
    logic [4:0]  out_rd;

    stage_memory dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_alu_out(in_alu_out),
        .in_mem_in_data(in_mem_in_data), .in_rd(in_rd), .in_funct3(in_funct3),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_mem_to_reg(in_mem_to_reg), .in_write_enable(in_write_enable),
        .out_dmem_req_valid(out_dmem_req_valid), .in_dmem_req_ready(in_dmem_req_ready),
        .out_dmem_addr(out_dmem_addr), .out_dmem_we(out_dmem_we),
        .out_dmem_wstrb(out_dmem_wstrb), .out_dmem_wdata(out_dmem_wdata),
        .in_dmem_resp_valid(in_dmem_resp_valid), .in_dmem_rdata(in_dmem_rdata),
        .out_stall(out_stall), .out_valid(out_valid), .out_rd(out_rd),
        .out_write_enable(out_write_enable), .out_mem_to_reg(out_mem_to_reg),
        .out_alu_out(out_alu_out), .out_mem_data(out_mem_data), .out_data(out_data),
        .out_misaligned(out_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp;
    } ld_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        int          rdy_delay;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
    } st_vec_t;

    ld_vec_t lv[8];
    st_vec_t sv[5];

    int n_assert = 0;
    int n_fail   = 0;

    // model state for the randomized run
    logic [31:0] mem[16];
    logic        accepted, pend, adv;
    int          cnt;
    logic        e_valid, e_we, e_m2r, e_mis;
    logic [4:0]  e_rd;
    logic [31:0] e_alu, e_mem;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        in_valid = 0; in_alu_out = 0; in_mem_in_data = 0; in_rd = 0; in_funct3 = 0;
        in_mem_read = 0; in_mem_write = 0; in_mem_to_reg = 0; in_write_enable = 0;
        in_dmem_req_ready = 0; in_dmem_resp_valid = 0; in_dmem_rdata = 0;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] d,
                         input logic [4:0] rd, input logic [2:0] f3, input logic r,
                         input logic w, input logic m2r, input logic we);
        in_valid = v; in_alu_out = alu; in_mem_in_data = d; in_rd = rd; in_funct3 = f3;
        in_mem_read = r; in_mem_write = w; in_mem_to_reg = m2r; in_write_enable = we;
    endtask

    task automatic do_load(input ld_vec_t v);
        drive(1, v.addr, 0, 5'd7, v.f3, 1, 0, 1, 1);
        in_dmem_req_ready = 1;
        @(negedge clk);
        chk("ld_req_valid", 32'(out_dmem_req_valid), 1);
        chk("ld_addr", out_dmem_addr, {v.addr[31:2], 2'b00});
        chk("ld_we", 32'(out_dmem_we), 0);
        chk("ld_stall_accept", 32'(out_stall), 1);
        tick;
        in_dmem_req_ready = 0;
        for (int c = 1; c < v.delay; c++) begin
            @(negedge clk);
            chk("ld_stall_wait", 32'(out_stall), 1);
            chk("ld_no_req_in_resp", 32'(out_dmem_req_valid), 0);
            chk("ld_bubble", 32'(out_valid), 0);
            tick;
        end
        in_dmem_resp_valid = 1;
        in_dmem_rdata = v.rdata;
        @(negedge clk);
        chk("ld_stall_resp", 32'(out_stall), 0);
        tick;
        clear_in;
        chk("ld_out_valid", 32'(out_valid), 1);
        chk("ld_mem_data", out_mem_data, v.exp);
        chk("ld_out_data", out_data, v.exp);
        chk("ld_out_rd", 32'(out_rd), 7);
        chk("ld_out_we", 32'(out_write_enable), 1);
    endtask

    task automatic do_store(input st_vec_t v);
        drive(1, v.addr, v.data, 5'd0, v.f3, 0, 1, 0, 0);
        in_dmem_req_ready = 0;
        for (int c = 0; c < v.rdy_delay; c++) begin
            @(negedge clk);
            chk("st_hold_valid", 32'(out_dmem_req_valid), 1);
            chk("st_hold_addr", out_dmem_addr, v.exp_addr);
            chk("st_hold_wstrb", 32'(out_dmem_wstrb), 32'(v.exp_wstrb));
            chk("st_hold_wdata", out_dmem_wdata, v.exp_wdata);
            chk("st_hold_we", 32'(out_dmem_we), 1);
            chk("st_hold_stall", 32'(out_stall), 1);
            tick;
            chk("st_bubble", 32'(out_valid), 0);
        end
        in_dmem_req_ready = 1;
        @(negedge clk);
        chk("st_acc_valid", 32'(out_dmem_req_valid), 1);
        chk("st_acc_addr", out_dmem_addr, v.exp_addr);
        chk("st_acc_wstrb", 32'(out_dmem_wstrb), 32'(v.exp_wstrb));
        chk("st_acc_wdata", out_dmem_wdata, v.exp_wdata);
        chk("st_acc_stall", 32'(out_stall), 0);
        tick;
        clear_in;
        chk("st_out_valid", 32'(out_valid), 1);
        chk("st_out_we", 32'(out_write_enable), 0);
        chk("st_out_mis", 32'(out_misaligned), 0);
    endtask

    function automatic logic [31:0] ext(input logic [2:0] f3, input int off, input logic [31:0] w);
        logic [31:0] s, b, h;
        s = w >> (8 * off);
        b = s % 256;
        h = s % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic check_regs;
        chk("rnd_valid", 32'(out_valid), 32'(e_valid));
        chk("rnd_rd", 32'(out_rd), 32'(e_rd));
        chk("rnd_we", 32'(out_write_enable), 32'(e_we));
        chk("rnd_m2r", 32'(out_mem_to_reg), 32'(e_m2r));
        chk("rnd_alu", out_alu_out, e_alu);
        chk("rnd_mem_data", out_mem_data, e_mem);
        chk("rnd_mis", 32'(out_misaligned), 32'(e_mis));
        chk("rnd_out_data", out_data, e_m2r ? e_mem : e_alu);
    endtask

    task automatic gen_instr;
        int k;
        k = $urandom_range(0, 9);
        in_rd = 5'($urandom);
        in_alu_out = $urandom;
        in_mem_in_data = $urandom;
        if (k < 2) begin
            drive(0, in_alu_out, in_mem_in_data, in_rd, 3'd0, 0, 0, 0, 0);
        end else if (k < 5) begin
            drive(1, in_alu_out, in_mem_in_data, in_rd, 3'($urandom), 0, 0, 0, 1'($urandom));
        end else if (k < 8) begin
            logic [2:0] f3;
            case ($urandom_range(0, 4))
                0: f3 = 3'd0;
                1: f3 = 3'd1;
                2: f3 = 3'd2;
                3: f3 = 3'd4;
                default: f3 = 3'd5;
            endcase
            drive(1, $urandom_range(0, 63), in_mem_in_data, in_rd, f3, 1, 0, 1, 1);
        end else begin
            drive(1, $urandom_range(0, 63), in_mem_in_data, in_rd, 3'($urandom_range(0, 2)),
                  1'($urandom), 1, 0, 0);
        end
    endtask

    task automatic rand_step;
        logic memop, st, mis, aligned, ereq, estall;
        int off, sz;
        logic [3:0]  ewstrb;
        logic [31:0] ewdata;
        memop = in_valid && (in_mem_read || in_mem_write);
        st    = in_mem_write;
        off   = int'(in_alu_out % 4);
        sz    = int'(in_funct3 % 4);
        mis   = memop && ((sz == 1 && off % 2 != 0) || (sz >= 2 && off != 0));
        aligned = memop && !mis;
        ereq  = aligned && !accepted;
        if (ereq)                      estall = !(st && in_dmem_req_ready);
        else if (aligned && accepted)  estall = !in_dmem_resp_valid;
        else                           estall = 0;
        if (sz == 0) begin
            ewstrb = 4'(1 << off);
            ewdata = (in_mem_in_data % 256) * 32'h01010101;
        end else if (sz == 1) begin
            ewstrb = 4'(3 << off);
            ewdata = (in_mem_in_data % 65536) * 32'h00010001;
        end else begin
            ewstrb = 4'hF;
            ewdata = in_mem_in_data;
        end
        chk("rnd_req_valid", 32'(out_dmem_req_valid), 32'(ereq));
        chk("rnd_stall", 32'(out_stall), 32'(estall));
        if (ereq) begin
            chk("rnd_addr", out_dmem_addr, in_alu_out - 32'(off));
            chk("rnd_req_we", 32'(out_dmem_we), 32'(st));
            if (st) begin
                chk("rnd_wstrb", 32'(out_dmem_wstrb), 32'(ewstrb));
                chk("rnd_wdata", out_dmem_wdata, ewdata);
            end
        end
        if (ereq && in_dmem_req_ready) begin
            if (st) begin
                for (int b = 0; b < 4; b++)
                    if (ewstrb[b]) mem[in_alu_out[5:2]][8*b +: 8] = ewdata[8*b +: 8];
            end else begin
                accepted = 1;
                pend = 1;
                cnt = $urandom_range(1, 3);
            end
        end
        if (!estall) begin
            e_valid = in_valid;
            e_rd    = in_rd;
            e_alu   = in_alu_out;
            e_m2r   = in_mem_to_reg;
            e_we    = in_write_enable && !mis;
            e_mis   = mis;
            if (aligned && !st) e_mem = ext(in_funct3, off, in_dmem_rdata);
            accepted = 0;
            adv = 1;
        end else begin
            e_valid = 0;
            e_we    = 0;
            e_mis   = 0;
            adv = 0;
        end
    endtask

    initial begin
        lv[0] = '{3'b000, 32'h103, 32'h80FF1234, 3, 32'hFFFFFF80};
        lv[1] = '{3'b100, 32'h103, 32'h80FF1234, 3, 32'h00000080};
        lv[2] = '{3'b001, 32'h102, 32'h80FF1234, 1, 32'hFFFF80FF};
        lv[3] = '{3'b101, 32'h102, 32'h80FF1234, 2, 32'h000080FF};
        lv[4] = '{3'b001, 32'h100, 32'h80FF1234, 1, 32'h00001234};
        lv[5] = '{3'b000, 32'h101, 32'h80FF1234, 1, 32'h00000012};
        lv[6] = '{3'b010, 32'h010, 32'hDEADBEEF, 1, 32'hDEADBEEF};
        lv[7] = '{3'b100, 32'h102, 32'h80FF1234, 2, 32'h000000FF};
        sv[0] = '{3'b001, 32'h202, 32'h0000ABCD, 2, 32'h200, 4'b1100, 32'hABCDABCD};
        sv[1] = '{3'b000, 32'h201, 32'h000000EF, 0, 32'h200, 4'b0010, 32'hEFEFEFEF};
        sv[2] = '{3'b010, 32'h300, 32'h12345678, 1, 32'h300, 4'b1111, 32'h12345678};
        sv[3] = '{3'b000, 32'h203, 32'h11223344, 1, 32'h200, 4'b1000, 32'h44444444};
        sv[4] = '{3'b001, 32'h200, 32'hFFFF5678, 0, 32'h200, 4'b0011, 32'h56785678};

        // reset values
        clear_in;
        #3;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_rd", 32'(out_rd), 0);
        chk("rst_we", 32'(out_write_enable), 0);
        chk("rst_m2r", 32'(out_mem_to_reg), 0);
        chk("rst_alu", out_alu_out, 0);
        chk("rst_mem_data", out_mem_data, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_mis", 32'(out_misaligned), 0);
        chk("rst_stall", 32'(out_stall), 0);
        chk("rst_req", 32'(out_dmem_req_valid), 0);
        tick;
        reset = 1;

        // reset in the middle of a load response wait
        drive(1, 32'h100, 0, 5'd9, 3'b010, 1, 0, 1, 1);
        in_dmem_req_ready = 1;
        @(negedge clk);
        chk("r1_accept_stall", 32'(out_stall), 1);
        tick;
        in_dmem_req_ready = 0;
        @(negedge clk);
        chk("r1_resp_stall", 32'(out_stall), 1);
        #2 reset = 0;
        #1;
        chk("r1_stall_async", 32'(out_stall), 0);
        chk("r1_req_async", 32'(out_dmem_req_valid), 0);
        chk("r1_valid_async", 32'(out_valid), 0);
        chk("r1_rd_async", 32'(out_rd), 0);
        clear_in;
        tick;
        reset = 1;
        in_dmem_resp_valid = 1;
        in_dmem_rdata = 32'hCAFEBABE;
        @(negedge clk);
        chk("r1_stray_stall", 32'(out_stall), 0);
        chk("r1_stray_req", 32'(out_dmem_req_valid), 0);
        tick;
        in_dmem_resp_valid = 0;
        chk("r1_stray_valid", 32'(out_valid), 0);
        chk("r1_stray_mem", out_mem_data, 0);
        tick;
        chk("r1_stray_valid2", 32'(out_valid), 0);

        // non-memory instruction
        drive(1, 32'h8, 0, 5'd5, 3'b000, 0, 0, 0, 1);
        @(negedge clk);
        chk("alu_req", 32'(out_dmem_req_valid), 0);
        chk("alu_stall", 32'(out_stall), 0);
        tick;
        clear_in;
        chk("alu_valid", 32'(out_valid), 1);
        chk("alu_rd", 32'(out_rd), 5);
        chk("alu_data", out_data, 32'h8);
        chk("alu_we", 32'(out_write_enable), 1);

        foreach (lv[i]) do_load(lv[i]);

        // load immediately followed by an ALU op, upstream held during stall
        drive(1, 32'h10, 0, 5'd4, 3'b010, 1, 0, 1, 1);
        in_dmem_req_ready = 1;
        @(negedge clk);
        chk("b2b_stall0", 32'(out_stall), 1);
        tick;
        in_dmem_req_ready = 0;
        in_dmem_resp_valid = 1;
        in_dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("b2b_stall1", 32'(out_stall), 0);
        tick;
        chk("b2b_ld_valid", 32'(out_valid), 1);
        chk("b2b_ld_data", out_data, 32'hDEADBEEF);
        in_dmem_resp_valid = 0;
        drive(1, 32'h5, 0, 5'd3, 3'b000, 0, 0, 0, 1);
        @(negedge clk);
        chk("b2b_add_stall", 32'(out_stall), 0);
        chk("b2b_add_req", 32'(out_dmem_req_valid), 0);
        tick;
        clear_in;
        chk("b2b_add_valid", 32'(out_valid), 1);
        chk("b2b_add_data", out_data, 32'h5);
        chk("b2b_add_rd", 32'(out_rd), 3);
        tick;
        chk("b2b_no_dup", 32'(out_valid), 0);

        foreach (sv[i]) do_store(sv[i]);

        // misaligned word load and halfword store
        drive(1, 32'h006, 0, 5'd2, 3'b010, 1, 0, 1, 1);
        in_dmem_req_ready = 1;
        @(negedge clk);
        chk("mis_lw_req", 32'(out_dmem_req_valid), 0);
        chk("mis_lw_stall", 32'(out_stall), 0);
        tick;
        drive(1, 32'h203, 32'h1234, 5'd0, 3'b001, 0, 1, 0, 0);
        chk("mis_lw_flag", 32'(out_misaligned), 1);
        chk("mis_lw_valid", 32'(out_valid), 1);
        chk("mis_lw_we", 32'(out_write_enable), 0);
        @(negedge clk);
        chk("mis_sh_req", 32'(out_dmem_req_valid), 0);
        chk("mis_sh_stall", 32'(out_stall), 0);
        tick;
        clear_in;
        chk("mis_sh_flag", 32'(out_misaligned), 1);
        tick;
        chk("mis_flag_clear", 32'(out_misaligned), 0);

        // randomized run against the model
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        clear_in;
        reset = 0;
        tick;
        reset = 1;
        e_valid = 0; e_we = 0; e_m2r = 0; e_mis = 0; e_rd = 0; e_alu = 0; e_mem = 0;
        accepted = 0; pend = 0; cnt = 0; adv = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) check_regs;
            if (adv) gen_instr;
            in_dmem_resp_valid = 0;
            in_dmem_rdata = $urandom;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    in_dmem_resp_valid = 1;
                    in_dmem_rdata = mem[in_alu_out[5:2]];
                    pend = 0;
                end
            end
            in_dmem_req_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            rand_step;
            tick;
        end
        check_regs;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- Pipeline stage 4 (MEM) of the RISC-V core. It consumes the execute-stage results: ALU result, store data, rd, and memory/writeback control.
- It performs the data-memory access over a valid/ready request channel plus a response channel, stalling the pipeline on variable latency.
- It registers the MEM/WB bundle, whose out_data feeds execute's in_MEMWB_out_data forwarding input and writeback.

Parameters:
- DATA_WIDTH, 32, width of data path and memory words.
- ADDR_WIDTH, 32, width of memory byte address.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  an EX/MEM instruction is present.
- in_alu_out  input  DATA_WIDTH  ALU result; the byte address for loads and stores.
- in_mem_in_data  input  DATA_WIDTH  store data (rs2, already forwarded).
- in_rd  input  5  destination register.
- in_funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- in_mem_read / in_mem_write  input  1 each  load / store.
- in_mem_to_reg / in_write_enable  input  1 each  writeback controls.
- out_dmem_req_valid  output  1  memory request valid.
- in_dmem_req_ready  input  1  memory accepts request.
- out_dmem_addr  output  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00}).
- out_dmem_we  output  1  1 = store.
- out_dmem_wstrb  output  4  byte enables.
- out_dmem_wdata  output  DATA_WIDTH  lane-aligned store data.
- in_dmem_resp_valid  input  1  load data valid.
- in_dmem_rdata  input  DATA_WIDTH  load data word.
- out_stall  output  1  hold IF/ID/EX and EX/MEM registers this cycle.
- out_valid  output  1  MEM/WB holds a valid instruction (0 = bubble).
- out_rd  output  5  registered rd.
- out_write_enable  output  1  registered write enable.
- out_mem_to_reg  output  1  registered mem_to_reg.
- out_alu_out  output  DATA_WIDTH  registered ALU result.
- out_mem_data  output  DATA_WIDTH  registered, extended load data.
- out_data  output  DATA_WIDTH  out_mem_to_reg ? out_mem_data : out_alu_out (combinational from registers).
- out_misaligned  output  1  registered one-cycle flag for a dropped misaligned access.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All registered outputs are 0.
  - out_dmem_req_valid = 0 and out_stall = 0 immediately.
  - Reset mid-transaction abandons it. A later in_dmem_resp_valid for that transaction, arriving while in IDLE, is ignored.
- FSM states: IDLE, REQ (request pending, not yet accepted), RESP (load accepted, awaiting data).
- IDLE, memory op present (in_valid & (read|write) & aligned):
  - out_dmem_req_valid = 1 combinationally.
  - If in_dmem_req_ready = 1: a store completes, with MEM/WB captured at the next edge and no stall; a load goes to RESP with out_stall = 1.
  - If in_dmem_req_ready = 0: go to REQ with out_stall = 1.
- REQ:
  - Hold the request (valid, addr, we, wstrb, wdata stable) until ready.
  - On acceptance: a store completes that cycle with out_stall = 0; a load goes to RESP with out_stall = 1.
- RESP:
  - out_dmem_req_valid = 0.
  - out_stall = !in_dmem_resp_valid.
  - On resp_valid: capture MEM/WB with the extended data and return to IDLE.
- Non-memory instruction or in_valid = 0:
  - No request, no stall; MEM/WB captured every cycle.
  - Latency 1 cycle; out_valid = in_valid.
- While out_stall = 1, MEM/WB captures a bubble: out_valid = 0 and out_write_enable = 0. Other fields hold their previous values.
- Load extension:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Store lanes:
  - SB: wstrb = 0001<<addr[1:0], wdata = byte replicated ×4.
  - SH: wstrb = 0011<<{addr[1],0}, wdata = half replicated ×2.
  - SW: wstrb = 1111.
- Misaligned accesses: halfword with addr[0] = 1, or word with addr[1:0] ≠ 00.
  - No memory request is issued and there is no stall.
  - MEM/WB is captured with out_valid = 1, out_write_enable = 0 and out_misaligned = 1 for one cycle.
- in_mem_read and in_mem_write both 1: treated as a store (read ignored).
- Back-to-back memory ops: a new request can be issued in IDLE in the cycle after a completion. There is never more than one outstanding transaction.

Test Plan:
1. Reset asserted mid-RESP (load to 0x100 accepted, resp_valid withheld), then resp_valid pulsed after release -> all outputs 0, FSM IDLE, out_stall = 0, the stray response is ignored and out_valid stays 0.
2. Non-memory op, alu_out = 0x00000008, rd = 5, write_enable = 1 -> next cycle out_valid = 1, out_rd = 5, out_data = 0x00000008, no request, out_stall never 1.
3. LB from addr 0x103, ready = 1, rdata = 0x80FF1234 returned 3 cycles later -> out_stall = 1 for 3 cycles; then out_mem_data = 0xFFFFFF80, out_data = 0xFFFFFF80 (mem_to_reg = 1). Repeat as LBU -> 0x00000080.
4. SH to addr 0x202 with data 0x0000ABCD, ready held 0 for 2 cycles -> req_valid/addr 0x200/wstrb 1100/wdata 0xABCDABCD stable in REQ; stall lasts 2 cycles and drops on the accept cycle; out_write_enable = 0 follows.
5. LW to addr 0x006 -> no request, out_stall = 0, next cycle out_misaligned = 1, out_valid = 1, out_write_enable = 0.
6. LW 0x10 (rdata 0xDEADBEEF, 1-cycle response) immediately followed by an ADD (alu_out = 0x5) -> the load completes with out_data = 0xDEADBEEF, the ADD is held during the stall and appears the next cycle with out_data = 0x5, with no bubble lost or duplicated.
